// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the DataPath.
// master: sequencer side (samples run/ir_in, drives control strobes and status).
// slave : DataPath / environment side (drives run/ir_in, observes strobes).
interface control_sequencer_if;
    logic        run;
    logic [31:0] ir_in;
    logic [31:0] Rin;
    logic [31:0] Rout;
    logic [15:0] ALUControl;
    logic        IRin;
    logic        MARin;
    logic        RYin;
    logic        MDRread;
    logic [3:0]  state;
    logic        halted;
    logic        illegal;

    modport master (
        input  run, ir_in,
        output Rin, Rout, ALUControl, IRin, MARin, RYin, MDRread, state, halted, illegal
    );

    modport slave (
        output run, ir_in,
        input  Rin, Rout, ALUControl, IRin, MARin, RYin, MDRread, state, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: runs each instruction as fetch/decode/execute T-states
// and decodes DataPath strobes from the current T-state and IR fields.
// Ports: clock, clear (async active-high reset), ctrl (control_sequencer_if.master:
// run/ir_in in; Rin/Rout/ALUControl/IRin/MARin/RYin/MDRread strobes and
// state/halted/illegal status out).
module control_sequencer #(
    parameter logic [15:0] INC_CODE    = 16'd20,
    parameter logic [4:0]  HALT_OPCODE = 5'd31
) (
    input logic                  clock,
    input logic                  clear,
    control_sequencer_if.master  ctrl
);
    localparam int unsigned RW = 32;
    localparam int unsigned AW = 16;

    localparam int unsigned HI_BIT    = 16;
    localparam int unsigned LO_BIT    = 17;
    localparam int unsigned ZHIGH_BIT = 18;
    localparam int unsigned ZLOW_BIT  = 19;
    localparam int unsigned PC_BIT    = 20;
    localparam int unsigned MDR_BIT   = 21;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd5,
        S_T1   = 4'd6,
        S_T2   = 4'd7,
        S_T3   = 4'd8,
        S_T4   = 4'd9,
        S_T5   = 4'd10,
        S_T6   = 4'd11,
        S_HALT = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_nop, is_halt, is_legal;
    state_t     eoi_state;

    logic [RW-1:0] rin_c, rout_c;
    logic [AW-1:0] alu_c;
    logic          irin_c, marin_c, ryin_c, mdrread_c;

    // Low IR bits carry immediates this unit does not use.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ctrl.ir_in[14:0];

    assign opcode = ctrl.ir_in[31:27];
    assign ra     = ctrl.ir_in[26:23];
    assign rb     = ctrl.ir_in[22:19];
    assign rc     = ctrl.ir_in[18:15];

    // Opcode classes.
    always_comb begin
        is_alu    = (opcode >= 5'd1) && (opcode <= 5'd8);
        is_muldiv = (opcode == 5'd14) || (opcode == 5'd15);
        is_nop    = (opcode == 5'd0);
        is_halt   = (opcode == HALT_OPCODE);
        is_legal  = is_alu || is_muldiv || is_nop || is_halt;
    end

    // Back-to-back instructions go straight to the next fetch.
    assign eoi_state = ctrl.run ? S_T0 : S_IDLE;

    // State and sticky illegal-opcode flag.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_T3) && !is_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        rin_c     = '0;
        rout_c    = '0;
        alu_c     = '0;
        irin_c    = 1'b0;
        marin_c   = 1'b0;
        ryin_c    = 1'b0;
        mdrread_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl.run) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                rout_c[PC_BIT]  = 1'b1;
                marin_c         = 1'b1;
                alu_c           = INC_CODE;
                rin_c[ZLOW_BIT] = 1'b1;
                state_d         = S_T1;
            end
            S_T1: begin
                rout_c[ZLOW_BIT] = 1'b1;
                rin_c[PC_BIT]    = 1'b1;
                rin_c[MDR_BIT]   = 1'b1;
                mdrread_c        = 1'b1;
                state_d          = S_T2;
            end
            S_T2: begin
                rout_c[MDR_BIT] = 1'b1;
                irin_c          = 1'b1;
                state_d         = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    rout_c[rb] = 1'b1;
                    ryin_c     = 1'b1;
                    state_d    = S_T4;
                end else if (is_muldiv) begin
                    rout_c[ra] = 1'b1;
                    ryin_c     = 1'b1;
                    state_d    = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = eoi_state;
                end
            end
            S_T4: begin
                alu_c           = AW'(opcode);
                rin_c[ZLOW_BIT] = 1'b1;
                if (is_muldiv) begin
                    rout_c[rb]       = 1'b1;
                    rin_c[ZHIGH_BIT] = 1'b1;
                end else begin
                    rout_c[rc] = 1'b1;
                end
                state_d = S_T5;
            end
            S_T5: begin
                rout_c[ZLOW_BIT] = 1'b1;
                if (is_muldiv) begin
                    rin_c[LO_BIT] = 1'b1;
                    state_d       = S_T6;
                end else begin
                    rin_c[ra] = 1'b1;
                    state_d   = eoi_state;
                end
            end
            S_T6: begin
                rout_c[ZHIGH_BIT] = 1'b1;
                rin_c[HI_BIT]     = 1'b1;
                state_d           = eoi_state;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ctrl.Rin        = rin_c;
    assign ctrl.Rout       = rout_c;
    assign ctrl.ALUControl = alu_c;
    assign ctrl.IRin       = irin_c;
    assign ctrl.MARin      = marin_c;
    assign ctrl.RYin       = ryin_c;
    assign ctrl.MDRread    = mdrread_c;
    assign ctrl.state      = state_q;
    assign ctrl.halted     = (state_q == S_HALT);
    assign ctrl.illegal    = illegal_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed vector table, hand-written corner
// sequences, and randomized traffic checked every cycle against a behavioural model.
module tb_control_sequencer;
    logic clock;
    logic clear;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .ctrl  (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [31:0] rin;
        logic [31:0] rout;
        logic [15:0] alu;
        logic        irin;
        logic        marin;
        logic        ryin;
        logic        mdrread;
        logic [3:0]  st;
        logic        halted;
        logic        ill;
    } outs_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int   m_mode = M_IDLE;
    int   m_step = 0;
    logic m_ill  = 1'b0;

    function automatic bit op_alu(input int op);
        return (op >= 1) && (op <= 8);
    endfunction

    function automatic bit op_md(input int op);
        return (op == 14) || (op == 15);
    endfunction

    function automatic bit op_legal(input int op);
        return (op == 0) || op_alu(op) || op_md(op) || (op == 31);
    endfunction

    // Cycles an instruction occupies, fetch included.
    function automatic int instr_len(input int op);
        if (op_alu(op)) return 6;
        if (op_md(op))  return 7;
        return 4;
    endfunction

    function automatic outs_t model_outs(input int mode, input int step, input logic [31:0] ir, input logic ill);
        outs_t o;
        int op, ra, rb, rc;
        op = int'(ir[31:27]);
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);
        o = '0;
        o.ill = ill;
        if (mode == M_HALT) begin
            o.st = 4'd15;
            o.halted = 1'b1;
        end else if (mode == M_RUN) begin
            o.st = 4'(5 + step);
            case (step)
                0: begin o.rout = 32'h100000; o.marin = 1'b1; o.alu = 16'd20; o.rin = 32'h80000; end
                1: begin o.rout = 32'h80000; o.rin = 32'h300000; o.mdrread = 1'b1; end
                2: begin o.rout = 32'h200000; o.irin = 1'b1; end
                3: begin
                    if (op_alu(op)) begin o.rout = 32'd1 << rb; o.ryin = 1'b1; end
                    if (op_md(op))  begin o.rout = 32'd1 << ra; o.ryin = 1'b1; end
                end
                4: begin
                    o.alu = 16'(op);
                    if (op_md(op)) begin o.rout = 32'd1 << rb; o.rin = 32'hC0000; end
                    else begin o.rout = 32'd1 << rc; o.rin = 32'h80000; end
                end
                5: begin
                    o.rout = 32'h80000;
                    o.rin = op_md(op) ? 32'h20000 : (32'd1 << ra);
                end
                6: begin o.rout = 32'h40000; o.rin = 32'h10000; end
                default: ;
            endcase
        end
        return o;
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_mode <= M_IDLE;
            m_step <= 0;
            m_ill  <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (bus.run) begin m_mode <= M_RUN; m_step <= 0; end
                M_RUN: begin
                    if ((m_step == 3) && !op_legal(int'(bus.ir_in[31:27]))) m_ill <= 1'b1;
                    if ((m_step == 3) && (bus.ir_in[31:27] == 5'd31)) m_mode <= M_HALT;
                    else if (m_step == instr_len(int'(bus.ir_in[31:27])) - 1) begin
                        if (bus.run) m_step <= 0;
                        else m_mode <= M_IDLE;
                    end else m_step <= m_step + 1;
                end
                default: ;
            endcase
        end
    end

    // Every cycle: DUT outputs versus model, sampled mid low phase.
    always @(negedge clock) begin
        outs_t a, e;
        #2;
        e = model_outs(m_mode, m_step, bus.ir_in, m_ill);
        a.rin = bus.Rin; a.rout = bus.Rout; a.alu = bus.ALUControl;
        a.irin = bus.IRin; a.marin = bus.MARin; a.ryin = bus.RYin; a.mdrread = bus.MDRread;
        a.st = bus.state; a.halted = bus.halted; a.ill = bus.illegal;
        chk("model", 128'(a), 128'(e));
        if (bus.Rout != 32'd0) chk("rout_onehot", 128'($onehot(bus.Rout)), 128'd1);
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] ir;
        int          len;
        logic [31:0] rout [4];
        logic [31:0] rin  [4];
        logic [15:0] alu4;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(negedge clock);
        #3;
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        bus.run = 1'b0;
        #3;
        chk("clear_state", 128'(bus.state), 128'd0);
        chk("clear_rin", 128'(bus.Rin), 128'd0);
        clear = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] code, input int max, input string name);
        int n;
        n = 0;
        while ((bus.state !== code) && (n < max)) begin
            tick();
            n++;
        end
        chk(name, 128'(bus.state), 128'(code));
    endtask

    initial begin
        clear = 1'b1;
        bus.run = 1'b0;
        bus.ir_in = 32'd0;

        // ir, len, rout T3..T6, rin T3..T6, ALUControl at T4
        vecs[0] = '{32'h79880000, 7, '{32'h8, 32'h2, 32'h80000, 32'h40000}, '{32'h0, 32'hC0000, 32'h20000, 32'h10000}, 16'd15};
        vecs[1] = '{32'h0A920000, 6, '{32'h4, 32'h10, 32'h80000, 32'h0}, '{32'h0, 32'h80000, 32'h20, 32'h0}, 16'd1};
        vecs[2] = '{32'h73C80000, 7, '{32'h80, 32'h200, 32'h80000, 32'h40000}, '{32'h0, 32'hC0000, 32'h20000, 32'h10000}, 16'd14};
        vecs[3] = '{32'h17870000, 6, '{32'h1, 32'h4000, 32'h80000, 32'h0}, '{32'h0, 32'h80000, 32'h8000, 32'h0}, 16'd2};
        vecs[4] = '{32'h00000000, 4, '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0}, 16'd0};

        repeat (2) @(negedge clock);
        #3;
        chk("reset_state", 128'(bus.state), 128'd0);
        chk("reset_illegal", 128'(bus.illegal), 128'd0);

        foreach (vecs[i]) begin
            do_clear();
            bus.ir_in = vecs[i].ir;
            bus.run = 1'b1;
            for (int s = 0; s < vecs[i].len; s++) begin
                tick();
                chk($sformatf("v%0d_state_t%0d", i, s), 128'(bus.state), 128'(5 + s));
                case (s)
                    0: begin
                        chk("fetch_t0_rout", 128'(bus.Rout), 128'h100000);
                        chk("fetch_t0_alu", 128'(bus.ALUControl), 128'd20);
                        chk("fetch_t0_rin", 128'(bus.Rin), 128'h80000);
                        chk("fetch_t0_marin", 128'(bus.MARin), 128'd1);
                    end
                    1: begin
                        chk("fetch_t1_rin", 128'(bus.Rin), 128'h300000);
                        chk("fetch_t1_mdrread", 128'(bus.MDRread), 128'd1);
                    end
                    2: begin
                        chk("fetch_t2_rout", 128'(bus.Rout), 128'h200000);
                        chk("fetch_t2_irin", 128'(bus.IRin), 128'd1);
                    end
                    default: begin
                        chk($sformatf("v%0d_rout_t%0d", i, s), 128'(bus.Rout), 128'(vecs[i].rout[s-3]));
                        chk($sformatf("v%0d_rin_t%0d", i, s), 128'(bus.Rin), 128'(vecs[i].rin[s-3]));
                        if (s == 3) chk($sformatf("v%0d_ryin", i), 128'(bus.RYin), 128'(vecs[i].len > 4));
                        if (s == 4) chk($sformatf("v%0d_alu", i), 128'(bus.ALUControl), 128'(vecs[i].alu4));
                    end
                endcase
            end
            tick();
            chk($sformatf("v%0d_next_t0", i), 128'(bus.state), 128'd5);
        end

        // Clear asserted mid-T4 of a div.
        do_clear();
        bus.ir_in = 32'h79880000;
        bus.run = 1'b1;
        tick();
        wait_state(4'd9, 10, "div_reach_t4");
        #1 clear = 1'b1;
        #1;
        chk("midclr_state", 128'(bus.state), 128'd0);
        chk("midclr_rin", 128'(bus.Rin), 128'd0);
        chk("midclr_rout", 128'(bus.Rout), 128'd0);
        chk("midclr_alu", 128'(bus.ALUControl), 128'd0);
        @(negedge clock);
        bus.run = 1'b0;
        clear = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_hold", 128'(bus.state), 128'd0);
        end

        // HALT: sticks with run high until clear.
        do_clear();
        bus.ir_in = 32'hF8000000;
        bus.run = 1'b1;
        tick();
        wait_state(4'd15, 10, "halt_reach");
        repeat (20) begin
            tick();
            chk("halt_state", 128'(bus.state), 128'd15);
            chk("halt_flag", 128'(bus.halted), 128'd1);
        end
        clear = 1'b1;
        #1;
        chk("halt_exit_state", 128'(bus.state), 128'd0);
        chk("halt_exit_flag", 128'(bus.halted), 128'd0);
        @(negedge clock);
        clear = 1'b0;

        // Illegal opcode then an add with run dropped during its T4.
        do_clear();
        bus.ir_in = 32'h48000000;
        bus.run = 1'b1;
        repeat (4) tick();
        chk("ill_t3_state", 128'(bus.state), 128'd8);
        chk("ill_before_edge", 128'(bus.illegal), 128'd0);
        tick();
        chk("ill_next_t0", 128'(bus.state), 128'd5);
        chk("ill_set", 128'(bus.illegal), 128'd1);
        bus.ir_in = 32'h0A920000;
        repeat (4) tick();
        chk("add_t4", 128'(bus.state), 128'd9);
        bus.run = 1'b0;
        tick();
        chk("add_t5", 128'(bus.state), 128'd10);
        chk("add_t5_rin", 128'(bus.Rin), 128'h20);
        chk("ill_sticky", 128'(bus.illegal), 128'd1);
        tick();
        chk("add_then_idle", 128'(bus.state), 128'd0);

        // Randomized traffic; the per-cycle model check does the comparing.
        do_clear();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            if (clear) clear = 1'b0;
            else if (bus.halted || ($urandom_range(0, 299) == 0)) clear = 1'b1;
            bus.run = ($urandom_range(0, 7) != 0);
            if (bus.state == 4'd5 || bus.state == 4'd0) begin
                logic [4:0] op;
                int pick;
                pick = int'($urandom_range(0, 9));
                if (pick < 5) op = 5'($urandom_range(1, 8));
                else if (pick < 7) op = 5'($urandom_range(14, 15));
                else op = 5'($urandom_range(0, 31));
                bus.ir_in = {op, 27'($urandom)};
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that drives the DataPath control inputs. Each instruction runs as a fetch/decode/execute sequence of one-clock T-states. The block reads the IR contents back from the DataPath and issues the Rin/Rout/ALUControl/IRin/MARin/RYin/MDRread strobes. It replaces bench-driven control sequences so the DataPath can run programs autonomously.

Parameters:
INC_CODE, 16'd20, ALUControl value that makes the ALU output Y-independent bus+1 (PC increment)
HALT_OPCODE, 5'd31, opcode that enters HALT

Ports:
clock  in  1  system clock; all state changes on posedge
clear  in  1  asynchronous, active-high reset
run  in  1  level enable; sampled at instruction boundaries
ir_in  in  32  current IR contents from DataPath
Rin  out  32  register-enable vector: [15:0] R0-R15, [16] HIin, [17] LOin, [18] ZHighin, [19] ZLowin, [20] PCin, [21] MDRin
Rout  out  32  bus-source vector: [15:0] R0-R15, [18] Zhighout, [19] Zlowout, [20] PCout, [21] MDRout
ALUControl  out  16  ALU operation code; 0 = no operation
IRin  out  1  IR load enable
MARin  out  1  MAR load enable
RYin  out  1  Y register load enable
MDRread  out  1  MDR selects memory data
state  out  4  current T-state code, for debug
halted  out  1  high while in HALT
illegal  out  1  sticky; set when an undefined opcode is decoded

Behaviour:
- Fields: opcode = ir_in[31:27], Ra = ir_in[26:23], Rb = ir_in[22:19], Rc = ir_in[18:15].
- State codes: IDLE=0, T0=5, T1=6, T2=7, T3=8, T4=9, T5=10, T6=11, HALT=15.
- State is registered. Strobes decode combinationally from state and ir_in, and are high for exactly the one cycle spent in that state.
- clear: state becomes IDLE immediately and illegal is cleared. While clear is high, every output is 0 and state = 0.
- IDLE: all strobes 0. Move to T0 when run = 1.
- T0: Rout[20], MARin, ALUControl = INC_CODE, Rin[19].
- T1: Rout[19], Rin[20], MDRread, Rin[21].
- T2: Rout[21], IRin. ir_in is valid from T3 onward.
- ALU register-register opcodes: 1 add, 2 sub, 3 and, 4 or, 5 shr, 6 shl, 7 ror, 8 rol.
  - T3: Rout[Rb], RYin.
  - T4: Rout[Rc], ALUControl = {11'b0, opcode}, Rin[19].
  - T5: Rout[19], Rin[Ra]. Then go to end-of-instruction.
  - Total 6 cycles.
- Opcodes 14 (mul) and 15 (div).
  - T3: Rout[Ra], RYin.
  - T4: Rout[Rb], ALUControl = {11'b0, opcode}, Rin[18], Rin[19].
  - T5: Rout[19], Rin[17] (LO).
  - T6: Rout[18], Rin[16] (HI).
  - Total 7 cycles.
- Opcode 0 (nop): T3 asserts nothing. End of instruction after T3; 4 cycles.
- HALT_OPCODE: T3 goes to HALT. HALT holds all strobes 0 and halted = 1. Only clear exits HALT.
- Any other opcode: treated as nop, and illegal is set at the T3 edge.
- End of instruction: go to T0 if run = 1, otherwise IDLE. There are no idle cycles between back-to-back instructions.
- Ra/Rb/Rc index only bits 0-15, so register fields never touch Rin/Rout[31:16]. Rin and Rout bits [31:22] are always 0.
- Never more than one Rout bit is high in any cycle.
- run falling mid-instruction has no effect; the instruction completes.

Test Plan:
- Reset: assert clear mid-T4 of a div -> on the same cycle state = 0, Rin = Rout = 0, ALUControl = 0; after release with run = 0, the block stays IDLE.
- div R3,R1: ir_in = 0x79880000, run = 1 -> sequence T0 through T6. T3: Rout = 0x8, RYin = 1. T4: Rout = 0x2, ALUControl = 15, Rin = 0xC0000. T5: Rout = 0x80000, Rin = 0x20000. T6: Rout = 0x40000, Rin = 0x10000. Next cycle is T0.
- add R5,R2,R4: ir_in = 0x0A920000 -> T3: Rout = 0x4, RYin = 1. T4: Rout = 0x10, ALUControl = 1, Rin = 0x80000. T5: Rout = 0x80000, Rin = 0x20. 6 cycles total.
- Fetch: every T0 has Rout = 0x100000, MARin = 1, ALUControl = 20, Rin = 0x80000. T1 has MDRread = 1 and Rin = 0x300000. T2 has Rout = 0x200000 and IRin = 1.
- halt: ir_in = 0xF8000000 -> after T3, state = 15 and halted = 1. It stays there 20 cycles with run = 1 and leaves only on clear.
- Illegal: ir_in = 0x48000000 (opcode 9) -> 4-cycle nop, illegal = 1 and sticky into the next instruction. Also deassert run during T4 of an add -> the add finishes, then state = IDLE.
